// File: rtl/ai_sched_pkg.sv
// Shared types and defaults for the AI lane spawn scheduler: FSM states, lane index,
// lane geometry defaults and the cooldown counter width helper.
package ai_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        PROBE = 2'd2,
        GRANT = 2'd3
    } sched_state_t;

    localparam int LANE_IDX_W = 2;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    localparam int DEF_LANE_X0       = 180;
    localparam int DEF_LANE_PITCH    = 60;
    localparam int DEF_LANE_COOLDOWN = 32;

    function automatic int cooldown_width(input int cooldown);
        return $clog2(cooldown + 1);
    endfunction

    // Pixel x of a lane; the result is truncated to the 11-bit screen coordinate.
    function automatic logic [10:0] lane_x(input int lane, input int x0, input int pitch);
        return 11'(x0 + lane * pitch);
    endfunction

endpackage

// File: rtl/ai_lane_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set req bit at or above ptr,
// wrapping modulo NUM_CARS. sel is one-hot, valid flags any request.
module rr_arbiter #(
    parameter  int NUM_CARS = 4,
    localparam int PW       = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
    input  logic [NUM_CARS-1:0] req,
    input  logic [PW-1:0]       ptr,
    output logic [NUM_CARS-1:0] sel,
    output logic                valid
);

    logic [2*NUM_CARS-1:0] req_dbl;
    logic [NUM_CARS-1:0]   req_rot;
    logic [NUM_CARS-1:0]   gnt_rot;
    logic [2*NUM_CARS-1:0] gnt_dbl;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
    assign req_dbl = {req, req};
    assign req_rot = NUM_CARS'(req_dbl >> ptr);
    assign gnt_rot = req_rot & (~req_rot + NUM_CARS'(1));
    assign gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    assign sel     = gnt_dbl[2*NUM_CARS-1:NUM_CARS];
    assign valid   = |req;

endmodule

// File: rtl/ai_lane_scheduler.sv
// Per-frame spawn scheduler: one round-robin grant per frame onto a free lane with cooldown.
// Optional statistics (spawn_count, frame_overrun) are built when AI_SCHED_STATS_EN is defined.
module ai_lane_scheduler
    import ai_sched_pkg::*;
#(
    parameter  int NUM_CARS      = 4,
    parameter  int NUM_LANES     = 4,
    parameter  int LANE_COOLDOWN = DEF_LANE_COOLDOWN,
    parameter  int LANE_X0       = DEF_LANE_X0,
    parameter  int LANE_PITCH    = DEF_LANE_PITCH,
    localparam int CAR_W         = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1,
    localparam int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int CD_W          = cooldown_width(LANE_COOLDOWN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [10:0]          random,
    input  logic [NUM_CARS-1:0]  spawn_req,
    output logic [NUM_CARS-1:0]  spawn_grant,
    output logic [10:0]          spawn_x,
    output logic [LANE_W-1:0]    spawn_lane,
    output logic [NUM_LANES-1:0] lanes_free,
    output logic                 busy
`ifdef AI_SCHED_STATS_EN
    ,
    output logic [15:0]          spawn_count,
    output logic                 frame_overrun
`endif
);

    sched_state_t        state_reg;
    logic [LANE_W-1:0]   cand_reg;
    logic [LANE_W-1:0]   probe_k_reg;
    logic [CAR_W-1:0]    sel_idx_reg;
    logic [CAR_W-1:0]    rr_ptr_reg;

    logic [NUM_CARS-1:0] arb_sel;
    logic                arb_valid;
    logic [CAR_W-1:0]    arb_idx;
    logic [CAR_W-1:0]    rr_ptr_next;
    logic [LANE_W-1:0]   probe_lane;
    logic                probe_hit;
    logic                take_grant;
    logic                frame_accept;
    logic                unused_random;

    assign unused_random = ^random[10:LANE_W];

    rr_arbiter #(
        .NUM_CARS (NUM_CARS)
    ) u_rr_arbiter (
        .req   (spawn_req),
        .ptr   (rr_ptr_reg),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (arb_sel[i]) begin
                arb_idx = CAR_W'(i);
            end
        end
    end

    assign rr_ptr_next  = (sel_idx_reg == CAR_W'(NUM_CARS - 1)) ? '0 : sel_idx_reg + CAR_W'(1);
    // Lane count is a power of two, so the index add wraps modulo NUM_LANES for free.
    assign probe_lane   = cand_reg + probe_k_reg;
    assign probe_hit    = (state_reg == PROBE) && lanes_free[probe_lane];
    assign take_grant   = probe_hit && spawn_req[sel_idx_reg];
    assign frame_accept = (state_reg == IDLE) && frame_start;
    assign busy         = (state_reg != IDLE);

    // Per-lane cooldown; decrement on an accepted frame, so it lands before this frame's probes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [CD_W-1:0] cd_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cd_reg <= '0;
                end else if (take_grant && (probe_lane == LANE_W'(gi))) begin
                    cd_reg <= CD_W'(LANE_COOLDOWN);
                end else if (frame_accept && (cd_reg != '0)) begin
                    cd_reg <= cd_reg - CD_W'(1);
                end
            end

            assign lanes_free[gi] = (cd_reg == '0);
        end
    endgenerate

    // The grant registers load on the winning probe edge, so the pulse is visible during GRANT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cand_reg    <= '0;
            probe_k_reg <= '0;
            sel_idx_reg <= '0;
            rr_ptr_reg  <= '0;
            spawn_grant <= '0;
            spawn_x     <= '0;
            spawn_lane  <= '0;
        end else begin
            spawn_grant <= '0;
            case (state_reg)
                IDLE: begin
                    if (frame_start) begin
                        cand_reg  <= random[LANE_W-1:0];
                        state_reg <= ARB;
                    end
                end
                ARB: begin
                    if (arb_valid) begin
                        sel_idx_reg <= arb_idx;
                        probe_k_reg <= '0;
                        state_reg   <= PROBE;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                PROBE: begin
                    if (probe_hit) begin
                        state_reg <= GRANT;
                        if (take_grant) begin
                            spawn_grant <= NUM_CARS'(1) << sel_idx_reg;
                            spawn_x     <= lane_x(int'(probe_lane), LANE_X0, LANE_PITCH);
                            spawn_lane  <= probe_lane;
                            rr_ptr_reg  <= rr_ptr_next;
                        end
                    end else if (probe_k_reg == LANE_W'(NUM_LANES - 1)) begin
                        state_reg <= IDLE;
                    end else begin
                        probe_k_reg <= probe_k_reg + LANE_W'(1);
                    end
                end
                GRANT: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef AI_SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spawn_count   <= '0;
            frame_overrun <= 1'b0;
        end else begin
            if (take_grant) begin
                spawn_count <= spawn_count + 16'd1;
            end
            if (frame_start && (state_reg != IDLE)) begin
                frame_overrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ai_lane_scheduler.sv
// Directed bench for ai_lane_scheduler: expected grants are queued per frame and
// matched against the DUT's grant pulses; AI_SCHED_STATS_EN adds the statistics checks.
module tb_ai_lane_scheduler;
    import ai_sched_pkg::*;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic [10:0] random;
    logic [3:0]  spawn_req;
    logic [3:0]  spawn_grant;
    logic [10:0] spawn_x;
    logic [1:0]  spawn_lane;
    logic [3:0]  lanes_free;
    logic        busy;
`ifdef AI_SCHED_STATS_EN
    logic [15:0] spawn_count;
    logic        frame_overrun;
`endif

    ai_lane_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .random      (random),
        .spawn_req   (spawn_req),
        .spawn_grant (spawn_grant),
        .spawn_x     (spawn_x),
        .spawn_lane  (spawn_lane),
        .lanes_free  (lanes_free),
        .busy        (busy)
`ifdef AI_SCHED_STATS_EN
        ,
        .spawn_count   (spawn_count),
        .frame_overrun (frame_overrun)
`endif
    );

    typedef struct {
        int car;
        int lane;
        int x;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   fs_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (spawn_grant !== 4'b0000) begin
            exp_t e;
            chk("grant_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                lane_idx_t el;
                e  = exp_q.pop_front();
                el = lane_idx_t'(e.lane);
                chk("grant_onehot", 32'(spawn_grant), 32'(4'b0001 << e.car));
                chk("grant_lane", 32'(spawn_lane), 32'(el));
                chk("grant_x", 32'(spawn_x), 32'(e.x));
                chk("grant_latency", 32'(cyc - fs_cyc), 32'(e.lat));
                $display("grant car=%0d lane=%0d x=%0d latency=%0d", e.car, e.lane, e.x, cyc - fs_cyc);
            end
        end
    end

    task automatic reset_dut();
        reset       = 1'b1;
        frame_start = 1'b0;
        spawn_req   = 4'b0000;
        random      = 11'd0;
        tick();
        tick();
        exp_q.delete();
        reset = 1'b0;
        tick();
    endtask

    // One frame: optional expected grant, expected busy duration, optional mid-frame req change.
    task automatic do_frame(input logic [10:0] rnd, input logic want, input int car, input int lane,
                            input int exp_busy, input int chg_at, input logic [3:0] chg_req);
        if (want) exp_q.push_back('{car, lane, 180 + 60 * lane, exp_busy - 1});
        random      = rnd;
        frame_start = 1'b1;
        fs_cyc      = cyc;
        tick();
        frame_start = 1'b0;
        while (busy && (cyc - fs_cyc) < 40) begin
            if (chg_at != 0 && (cyc - fs_cyc) == chg_at) spawn_req = chg_req;
            tick();
        end
        chk("busy_cycles", 32'(cyc - fs_cyc), 32'(exp_busy));
        chk("grant_pending", 32'(exp_q.size()), 32'd0);
        $display("frame rnd=%0d req=%b want=%0d busy_cycles=%0d lanes_free=%b",
                 rnd, spawn_req, want, cyc - fs_cyc, lanes_free);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        random      = 11'd0;
        spawn_req   = 4'b0000;

        // Reset state
        reset_dut();
        chk("rst_grant", 32'(spawn_grant), 32'd0);
        chk("rst_x", 32'(spawn_x), 32'd0);
        chk("rst_lane", 32'(spawn_lane), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lanes_free", 32'(lanes_free), 32'hF);
`ifdef AI_SCHED_STATS_EN
        chk("rst_count", 32'(spawn_count), 32'd0);
        chk("rst_overrun", 32'(frame_overrun), 32'd0);
`endif

        // Single request, random=2 -> lane 2 at x=300
        spawn_req = 4'b0001;
        do_frame(11'd2, 1'b1, 0, 2, 4, 0, 4'b0);
        chk("s1_lanes_free", 32'(lanes_free), 32'b1011);
        chk("s1_x_held", 32'(spawn_x), 32'd300);
`ifdef AI_SCHED_STATS_EN
        chk("s1_count", 32'(spawn_count), 32'd1);
`endif

        // Two requesters, random=1 twice: second frame skips the cooling lane
        reset_dut();
        spawn_req = 4'b0011;
        do_frame(11'd1, 1'b1, 0, 1, 4, 0, 4'b0);
        do_frame(11'd1, 1'b1, 1, 2, 5, 0, 4'b0);
        chk("s2_lanes_free", 32'(lanes_free), 32'b1001);

        // Four requesters, random=0: lanes fill up, fifth frame probes all and gives up
        reset_dut();
        spawn_req = 4'b1111;
        do_frame(11'd0, 1'b1, 0, 0, 4, 0, 4'b0);
        do_frame(11'd0, 1'b1, 1, 1, 5, 0, 4'b0);
        do_frame(11'd0, 1'b1, 2, 2, 6, 0, 4'b0);
        do_frame(11'd0, 1'b1, 3, 3, 7, 0, 4'b0);
        do_frame(11'd0, 1'b0, 0, 0, 6, 0, 4'b0);
        chk("s3_lanes_free", 32'(lanes_free), 32'b0000);

        // Cooldown boundary: lane 0 granted in frame F is free again in frame F+32
        reset_dut();
        spawn_req = 4'b0001;
        do_frame(11'd0, 1'b1, 0, 0, 4, 0, 4'b0);
        do_frame(11'd1, 1'b1, 0, 1, 4, 0, 4'b0);
        do_frame(11'd2, 1'b1, 0, 2, 4, 0, 4'b0);
        do_frame(11'd3, 1'b1, 0, 3, 4, 0, 4'b0);
        for (int f = 4; f < 32; f++) begin
            do_frame(11'd0, 1'b0, 0, 0, 6, 0, 4'b0);
        end
        chk("s4_lane0_blocked_f31", 32'(lanes_free[0]), 32'd0);
        do_frame(11'd0, 1'b1, 0, 0, 4, 0, 4'b0);

        // Request dropped during PROBE: no grant, no reservation, rr_ptr kept
        reset_dut();
        spawn_req = 4'b0011;
        do_frame(11'd0, 1'b1, 0, 0, 4, 0, 4'b0);
        do_frame(11'd0, 1'b0, 0, 0, 5, 2, 4'b0001);
        chk("s5_lanes_free", 32'(lanes_free), 32'b1110);
        chk("s5_x_held", 32'(spawn_x), 32'd180);
        spawn_req = 4'b0011;
        do_frame(11'd0, 1'b1, 1, 1, 5, 0, 4'b0);

        // frame_start while busy is dropped and flagged as an overrun
        reset_dut();
        spawn_req = 4'b0001;
        do_frame(11'd0, 1'b1, 0, 0, 4, 0, 4'b0);
        exp_q.push_back('{0, 1, 240, 3});
        random      = 11'd1;
        frame_start = 1'b1;
        fs_cyc      = cyc;
        tick();
        frame_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        tick();
        chk("s6_no_rescan_busy", 32'(busy), 32'd0);
        chk("s6_pending", 32'(exp_q.size()), 32'd0);
`ifdef AI_SCHED_STATS_EN
        chk("s6_count", 32'(spawn_count), 32'd2);
        chk("s6_overrun", 32'(frame_overrun), 32'd1);
`endif

        // Reset asserted during PROBE aborts the grant
        random      = 11'd2;
        frame_start = 1'b1;
        fs_cyc      = cyc;
        tick();
        frame_start = 1'b0;
        tick();
        chk("s7_in_probe_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("s7_async_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("s7_grant", 32'(spawn_grant), 32'd0);
        chk("s7_x", 32'(spawn_x), 32'd0);
        chk("s7_lanes_free", 32'(lanes_free), 32'hF);
        chk("s7_busy", 32'(busy), 32'd0);
`ifdef AI_SCHED_STATS_EN
        chk("s7_count", 32'(spawn_count), 32'd0);
        chk("s7_overrun", 32'(frame_overrun), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
